// File: rtl/evr_pkt_buf_pkg.sv
// Shared types and constants for the EVR dual-bank packet buffer.
// Holds the write FSM state encoding and the FaultCode values.
package evr_pkt_buf_pkg;

   typedef enum logic [1:0] {
      W_IDLE,
      W_RX,
      W_CK,
      W_CMP
   } wstate_e;

   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_CSUM    = 2'b01;
   localparam logic [1:0] FC_TIMEOUT = 2'b10;
   localparam logic [1:0] FC_OVERRUN = 2'b11;

   localparam logic [7:0] EOP_CHAR_DEFAULT = 8'h3C;

endpackage

// File: rtl/pkt_dpram.sv
// Simple dual-port RAM: write on the receive clock, registered read
// on the system clock. Address is {bank, sample index}.
module pkt_dpram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned AW     = 12
) (
   input  logic              wclk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              rclk_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**AW];

   always_ff @(posedge wclk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge rclk_i) begin
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/dual_bank_packet_buffer.sv
// Ping-pong receive buffer for EVR data-buffer packets: stores decimated
// samples, checks the trailer checksum, and hands committed banks to the reader.
module dual_bank_packet_buffer
   import evr_pkt_buf_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 11,
   parameter int unsigned DECIMATE = 2,
   parameter int unsigned CSUM_W   = 16,
   parameter logic [7:0]  EOP_CHAR = EOP_CHAR_DEFAULT,
   localparam int unsigned SIZE_W  = ADDR_W + $clog2(DECIMATE) + 1
) (
   input  logic              RxClock,
   input  logic              Reset,
   input  logic              SysClock,
   input  logic              PacketStart,
   input  logic              PacketStop,
   input  logic [DATA_W-1:0] DataIn,
   input  logic [ADDR_W-1:0] Address,
   output logic [DATA_W-1:0] DataOut,
   input  logic              ReadEna,
   output logic              PacketReady,
   output logic              ReadBank,
   output logic [SIZE_W-1:0] PacketSize,
   output logic              PacketFault,
   output logic [1:0]        FaultCode,
   output logic              Overrun,
   output logic [15:0]       DropCount
);

   localparam int unsigned CK_N = CSUM_W / DATA_W;
   localparam int unsigned CK_W = $clog2(CK_N) + 1;
   localparam logic [CK_W-1:0]   CK_LAST  = CK_W'(CK_N - 1);
   localparam logic [1:0]        PH_LAST  = 2'(DECIMATE - 1);
   localparam logic [SIZE_W-1:0] OFF_LAST = SIZE_W'(DECIMATE * (2**ADDR_W) - 1);

   wstate_e                 state_q, state_d;
   logic                    wbank_q, wbank_d;
   logic                    rbank_q, rbank_d;
   logic [1:0]              full_q, full_d;
   logic [1:0][SIZE_W-1:0]  size_q, size_d;
   logic [SIZE_W-1:0]       off_q, off_d;
   logic [1:0]              ph_q, ph_d;
   logic [ADDR_W-1:0]       wa_q, wa_d;
   logic [CSUM_W-1:0]       sum_q, sum_d;
   logic [CSUM_W-1:0]       csum_q, csum_d;
   logic [CK_W-1:0]         ck_q, ck_d;
   logic [SIZE_W-1:0]       len_q, len_d;
   logic [1:0]              fcode_q, fcode_d;
   logic                    fault_q, fault_d;
   logic                    ovr_q, ovr_d;
   logic                    ready_q, ready_d;
   logic [15:0]             drop_q, drop_d;

   logic                    rx_cyc;
   logic                    restart;
   logic                    samp;
   logic                    release_rd;
   logic                    we;
   logic [ADDR_W:0]         waddr;
   logic [SIZE_W-1:0]       c_off;
   logic [1:0]              c_ph;
   logic [ADDR_W-1:0]       c_wa;
   logic [CSUM_W-1:0]       c_sum;
   logic [CSUM_W-1:0]       exp_csum;

   assign exp_csum = {CSUM_W{1'b1}} - sum_q + CSUM_W'(EOP_CHAR);

   always_comb begin
      state_d = state_q;
      wbank_d = wbank_q;
      rbank_d = rbank_q;
      full_d  = full_q;
      size_d  = size_q;
      off_d   = off_q;
      ph_d    = ph_q;
      wa_d    = wa_q;
      sum_d   = sum_q;
      csum_d  = csum_q;
      ck_d    = ck_q;
      len_d   = len_q;
      fcode_d = fcode_q;
      fault_d = 1'b0;
      ovr_d   = 1'b0;
      drop_d  = drop_q;
      rx_cyc  = 1'b0;
      restart = 1'b0;

      unique case (state_q)
         W_IDLE: begin
            if (PacketStart && full_q[wbank_q]) begin
               ovr_d   = 1'b1;
               fcode_d = FC_OVERRUN;
            end else if (PacketStart) begin
               state_d = W_RX;
               rx_cyc  = 1'b1;
               restart = 1'b1;
            end
         end
         W_RX: begin
            rx_cyc  = 1'b1;
            restart = PacketStart;
         end
         W_CK: begin
            csum_d = CSUM_W'({csum_q, DataIn});
            ck_d   = ck_q + CK_W'(1);
            if (ck_q == CK_LAST) state_d = W_CMP;
         end
         W_CMP: begin
            state_d = W_IDLE;
            if (csum_q == exp_csum) begin
               full_d[wbank_q] = 1'b1;
               size_d[wbank_q] = len_q;
               wbank_d         = ~wbank_q;
            end else begin
               fault_d = 1'b1;
               fcode_d = FC_CSUM;
            end
         end
      endcase

      // A Start cycle is offset 0 of a fresh packet, in IDLE or mid-packet.
      c_off = restart ? '0 : off_q;
      c_ph  = restart ? '0 : ph_q;
      c_wa  = restart ? '0 : wa_q;
      c_sum = restart ? '0 : sum_q;
      samp  = rx_cyc && (c_ph == 2'd0);
      we    = samp;
      waddr = {wbank_q, c_wa};

      if (rx_cyc) begin
         off_d = c_off + SIZE_W'(1);
         ph_d  = (c_ph == PH_LAST) ? 2'd0 : c_ph + 2'd1;
         wa_d  = samp ? c_wa + ADDR_W'(1) : c_wa;
         sum_d = samp ? c_sum + CSUM_W'(DataIn) : c_sum;
         if (state_q == W_RX && !PacketStart) begin
            if (PacketStop) begin
               state_d = W_CK;
               len_d   = c_off + SIZE_W'(1);
               ck_d    = '0;
            end else if (c_off == OFF_LAST) begin
               state_d = W_IDLE;
               fault_d = 1'b1;
               fcode_d = FC_TIMEOUT;
            end
         end
      end

      release_rd = ReadEna && ready_q;
      if (release_rd) begin
         full_d[rbank_q] = 1'b0;
         rbank_d         = ~rbank_q;
      end
      ready_d = full_d[rbank_d] && !release_rd;

      if ((fault_d || ovr_d) && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge RxClock) begin
      if (Reset) begin
         state_q <= W_IDLE;
         wbank_q <= 1'b0;
         rbank_q <= 1'b0;
         full_q  <= '0;
         size_q  <= '0;
         off_q   <= '0;
         ph_q    <= '0;
         wa_q    <= '0;
         sum_q   <= '0;
         csum_q  <= '0;
         ck_q    <= '0;
         len_q   <= '0;
         fcode_q <= FC_NONE;
         fault_q <= 1'b0;
         ovr_q   <= 1'b0;
         ready_q <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         full_q  <= full_d;
         size_q  <= size_d;
         off_q   <= off_d;
         ph_q    <= ph_d;
         wa_q    <= wa_d;
         sum_q   <= sum_d;
         csum_q  <= csum_d;
         ck_q    <= ck_d;
         len_q   <= len_d;
         fcode_q <= fcode_d;
         fault_q <= fault_d;
         ovr_q   <= ovr_d;
         ready_q <= ready_d;
         drop_q  <= drop_d;
      end
   end

   assign PacketReady = ready_q;
   assign ReadBank    = rbank_q;
   assign PacketSize  = size_q[rbank_q];
   assign PacketFault = fault_q;
   assign FaultCode   = fcode_q;
   assign Overrun     = ovr_q;
   assign DropCount   = drop_q;

   pkt_dpram #(
      .DATA_W (DATA_W),
      .AW     (ADDR_W + 1)
   ) u_ram (
      .wclk_i  (RxClock),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (DataIn),
      .rclk_i  (SysClock),
      .raddr_i ({ReadBank, Address}),
      .rdata_o (DataOut)
   );

endmodule
